sevseg_scan_ctrl: RTL

Parametrised multiplexed seven-segment scanner for the board debug display. It drives NUM_DIGITS common-anode digits from a packed hex value. Improvements over the first-generation scanner:
- runs entirely on clk through a clock-enable tick, with no derived clocks
- double-buffered value with tear-free update at frame boundaries
- per-digit decimal points
- leading-zero blanking
- PWM brightness and inter-digit ghost blanking

---
 rtl/sevseg_scan_if.sv | 50 +++++
 rtl/sevseg_scan_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sevseg_scan_if.sv
// sevseg_scan_if
// Bundles the scanner's control inputs, display outputs and debug taps.
//
// Signals (direction as seen by the scanner, modport slave):
//   en         in   scan enable; low freezes the scan and blanks the display
//   value      in   packed hex nibbles, digit i = value[4i+3:4i]
//   load       in   capture value/dp_mask into the shadow register this cycle
//   dp_mask    in   1 = light decimal point of digit i
//   blank_lz   in   suppress leading zeros
//   bright     in   brightness, 0 = dimmest, all-ones = full
//   an         out  anode enables, active-low
//   seg        out  segments {a,b,c,d,e,f,g}, active-low
//   dp         out  decimal point, active-low
//   frame_done out  one-cycle pulse at the end of the last digit's slot
//   dbg_slot_cnt / dbg_dig_idx  out  live scan position
//
// Handshake: there is no valid/ready pair. load is a single-cycle strobe that
// is always accepted; value and dp_mask are sampled on every edge where load
// is high, and the last strobe before a frame boundary is the one displayed.
interface sevseg_scan_if #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 1000,
    parameter int BRIGHT_W   = 4
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    en;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    blank_lz;
    logic [BRIGHT_W-1:0]     bright;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;
    logic [CNT_W-1:0]        dbg_slot_cnt;
    logic [IDX_W-1:0]        dbg_dig_idx;

    modport master (
        output en, value, load, dp_mask, blank_lz, bright,
        input  an, seg, dp, frame_done, dbg_slot_cnt, dbg_dig_idx
    );

    modport slave (
        input  en, value, load, dp_mask, blank_lz, bright,
        output an, seg, dp, frame_done, dbg_slot_cnt, dbg_dig_idx
    );
endinterface

// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl
// Multiplexed common-anode seven-segment scanner running entirely on clk.
// Each digit owns a slot of CLK_DIV cycles; the anode is held off for the
// first BLANK_CYC cycles of a slot (ghost blanking) and after on_limit cycles
// (PWM brightness). A shadow register takes loads at any time and is copied
// into the display register only at the frame boundary, so frames never tear.
//
// Ports:
//   clk  in  system clock
//   Rst  in  synchronous reset, active-high
//   bus  sevseg_scan_if.slave (controls, an/seg/dp/frame_done, debug taps)
module sevseg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 1000,
    parameter int BRIGHT_W   = 4,
    parameter int BLANK_CYC  = 2
) (
    input  logic         clk,
    input  logic         Rst,
    sevseg_scan_if.slave bus
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Wide enough that (bright+1)*CLK_DIV can never overflow.
    localparam int LIM_W = BRIGHT_W + 33;

    logic [CNT_W-1:0]        slot_cnt;
    logic [IDX_W-1:0]        dig_idx;
    logic [4*NUM_DIGITS-1:0] sh_val, disp_val;
    logic [NUM_DIGITS-1:0]   sh_dp, disp_dp;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    frame_done_q;

    logic                    slot_last, dig_last, frame_wrap;
    logic [LIM_W-1:0]        on_limit;
    logic                    lit_d;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic                    zero_above;
    logic [3:0]              nib_sel;
    logic                    dp_sel, blank_sel;
    logic [NUM_DIGITS-1:0]   an_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    assign slot_last  = (slot_cnt == CNT_W'(CLK_DIV - 1));
    // >= so an out-of-range index also wraps back to digit 0.
    assign dig_last   = (dig_idx >= IDX_W'(NUM_DIGITS - 1));
    assign frame_wrap = bus.en && slot_last && dig_last;

    assign on_limit = ((LIM_W'(bus.bright) + LIM_W'(1)) * LIM_W'(CLK_DIV)) >> BRIGHT_W;
    assign lit_d    = bus.en
                   && (LIM_W'(slot_cnt) >= LIM_W'(BLANK_CYC))
                   && (LIM_W'(slot_cnt) <  on_limit);

    always_comb begin
        lz_vec     = '0;
        zero_above = 1'b1;
        nib_sel    = 4'h0;
        dp_sel     = 1'b0;
        blank_sel  = 1'b0;
        an_d       = '1;
        // Walk from the most significant digit down: a digit is a leading
        // zero only if it and every digit above it are zero.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp_val[4*i +: 4] == 4'h0);
            lz_vec[i]  = bus.blank_lz && zero_above && (i != 0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_idx == IDX_W'(i)) begin
                nib_sel   = disp_val[4*i +: 4];
                dp_sel    = disp_dp[i];
                blank_sel = lz_vec[i];
                an_d[i]   = ~lit_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            slot_cnt     <= '0;
            dig_idx      <= '0;
            sh_val       <= '0;
            sh_dp        <= '0;
            disp_val     <= '0;
            disp_dp      <= '0;
            an_q         <= '1;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            if (bus.load) begin
                sh_val <= bus.value;
                sh_dp  <= bus.dp_mask;
            end
            // Copies the pre-edge shadow, so a load on this same edge
            // lands in the following frame.
            if (frame_wrap) begin
                disp_val <= sh_val;
                disp_dp  <= sh_dp;
            end
            if (bus.en) begin
                if (slot_last) begin
                    slot_cnt <= '0;
                    dig_idx  <= dig_last ? '0 : dig_idx + IDX_W'(1);
                end else begin
                    slot_cnt <= slot_cnt + CNT_W'(1);
                end
            end
            frame_done_q <= frame_wrap;
            // seg/dp are constant within a slot, so they only change on a
            // slot edge, which is also where the anode drops for BLANK_CYC.
            an_q  <= an_d;
            seg_q <= (bus.en && !blank_sel) ? hex7(nib_sel) : 7'b1111111;
            dp_q  <= bus.en ? ~dp_sel : 1'b1;
        end
    end

    assign bus.an           = an_q;
    assign bus.seg          = seg_q;
    assign bus.dp           = dp_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.dbg_slot_cnt = slot_cnt;
    assign bus.dbg_dig_idx  = dig_idx;
endmodule
